// File: rtl/uart_rx.sv
// uart_rx: 8N1 (or 8E1 with UART_RX_PARITY_EN) serial receiver feeding a
// show-ahead byte FIFO with a valid/ready consumer handshake.
//
// Optional feature macro: UART_RX_PARITY_EN (adds even-parity bit, 8E1).
//
// Ports:
//   clk            in   system clock
//   reset_low      in   synchronous active-low reset
//   rx             in   asynchronous serial line, idles high
//   host_ready     in   consumer accepts host_byte this cycle
//   host_valid     out  FIFO non-empty, host_byte valid
//   host_byte      out  FIFO head byte (0 while empty)
//   framing_error  out  sticky, stop bit sampled low
//   overrun        out  sticky, byte dropped because FIFO full
//   parity_error   out  sticky, parity mismatch (0 unless parity enabled)
module uart_rx #(
    parameter int CLOCK_HZ   = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       rx,
    input  logic       host_ready,
    output logic       host_valid,
    output logic [7:0] host_byte,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] LAST_FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_HALF = BW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic          r_rx_prev;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_ferr;
    logic          r_ovr;

    logic          w_fall;
    logic          w_tick;
    logic          w_shift_en;
    logic          w_stop_smp;
    logic          w_push;
    logic          w_ferr_set;
    logic          w_par_ok;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // A held-low line never shows a new 1->0 edge, so a break
    // cannot retrigger the receiver until the line goes high again.
    assign w_fall = r_rx_prev & ~r_rx_s;
    assign w_tick = (r_state == S_START) ? (r_baud == LAST_HALF)
                                         : (r_baud == LAST_FULL);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_tick) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_tick && (r_bit == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_tick) w_next = S_STOP;
`endif
            S_STOP:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_shift_en = (r_state == S_DATA) && w_tick;
        w_stop_smp = (r_state == S_STOP) && w_tick;
        w_push     = w_stop_smp && r_rx_s && w_par_ok;
        w_ferr_set = w_stop_smp && !r_rx_s;
    end

    // Baud timing, bit count and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if ((r_state == S_IDLE) || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (r_state == S_START) begin
                r_bit <= 3'd0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;
    logic w_par_smp;

    assign w_par_smp = (r_state == S_PARITY) && w_tick;
    assign w_par_ok  = !r_par_bad;

    // Even parity: XOR over data plus parity bit must be 0.
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bad <= ^{r_shift, r_rx_s};
            if (^{r_shift, r_rx_s}) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign parity_error = r_perr;
`else
    assign w_par_ok     = 1'b1;
    assign parity_error = 1'b0;
`endif

    // Show-ahead FIFO; a push into a full FIFO is accepted only when
    // the head is being popped on the same edge.
    assign host_valid = (r_count != '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = host_valid && host_ready;
    assign w_wr       = w_push && (!w_full || w_pop);
    assign host_byte  = host_valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CW'(1);
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign framing_error = r_ferr;
    assign overrun       = r_ovr;

endmodule
